// File: rtl/led_sequence_player_if.sv
// dmem-side bus of the LED sequence player: processor writes plus the status read path.
interface led_sequence_player_if;
   logic        wEn;
   logic [11:0] addr;
   logic [31:0] dataIn;
   logic        stat_sel;
   logic [31:0] status;

   modport master (output wEn, addr, dataIn, input stat_sel, status);
   modport slave  (input wEn, addr, dataIn, output stat_sel, status);
endinterface

// File: rtl/led_sequence_player.sv
// Memory-mapped LED pattern player: colours queue in a FIFO and are replayed with fixed
// on/gap timing once the processor issues start.
module led_sequence_player #(
   parameter int DEPTH      = 32,
   parameter int ON_CYCLES  = 25000000,
   parameter int GAP_CYCLES = 12500000,
   parameter int PUSH_ADDR  = 8,
   parameter int CTRL_ADDR  = 9,
   parameter int STAT_ADDR  = 10
) (
   input  logic                        clock,
   input  logic                        reset,
   led_sequence_player_if.slave        bus,
   output logic                        busy,
   output logic                        red_led,
   output logic                        blue_led,
   output logic                        green_led,
   output logic                        yellow_led
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [1:0]  ST_IDLE  = 2'd0;
   localparam logic [1:0]  ST_ON    = 2'd1;
   localparam logic [1:0]  ST_GAP   = 2'd2;
   localparam logic [31:0] ON_LOAD  = 32'(ON_CYCLES - 1);
   localparam logic [31:0] GAP_LOAD = 32'(GAP_CYCLES - 1);

   logic [1:0]    state_q, state_d;
   logic [31:0]   timer_q, timer_d;
   logic [1:0]    colour_q, colour_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          done_q, done_d;
   logic          overflow_q, overflow_d;
   logic [3:0]    leds_q, leds_d;
   logic          busy_q, busy_d;
   logic [1:0]    mem_q [DEPTH];
   logic [1:0]    mem_d [DEPTH];

   logic          push_s, ctrl_s, clear_s, start_s, full_s, do_push_s, pop_s;
   logic [1:0]    head_s;
   logic [7:0]    count8_s;
   logic          unused_s;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         ptr_next = {PW{1'b0}};
      end else begin
         ptr_next = p + PW'(1);
      end
   endfunction

   // Address decode and status word
   always_comb begin
      push_s    = bus.wEn && (bus.addr == 12'(PUSH_ADDR));
      ctrl_s    = bus.wEn && (bus.addr == 12'(CTRL_ADDR));
      clear_s   = ctrl_s && bus.dataIn[1];
      start_s   = ctrl_s && bus.dataIn[0] && !clear_s;
      full_s    = (count_q == CW'(DEPTH));
      do_push_s = push_s && !full_s && !clear_s;
      head_s    = mem_q[rd_ptr_q];
      count8_s  = 8'(count_q);
      unused_s  = ^bus.dataIn[31:2];
   end

   assign bus.stat_sel = (bus.addr == 12'(STAT_ADDR));
   assign bus.status   = {16'h0000, count8_s, 5'b00000, overflow_q, done_q, busy_q};

   // Playback sequencer; clear overrides everything, including a pending pop
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      colour_d = colour_q;
      done_d   = done_q;
      pop_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               if (count_q != {CW{1'b0}}) begin
                  done_d   = 1'b0;
                  colour_d = head_s;
                  timer_d  = ON_LOAD;
                  state_d  = ST_ON;
               end else begin
                  done_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ON: begin
            if (timer_q == 32'd0) begin
               pop_s   = 1'b1;
               timer_d = GAP_LOAD;
               state_d = ST_GAP;
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         ST_GAP: begin
            if (timer_q == 32'd0) begin
               if (count_q != {CW{1'b0}}) begin
                  colour_d = head_s;
                  timer_d  = ON_LOAD;
                  state_d  = ST_ON;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = 32'd0;
         end
      endcase
      if (clear_s) begin
         state_d = ST_IDLE;
         timer_d = 32'd0;
         done_d  = 1'b0;
         pop_s   = 1'b0;
      end else begin
         pop_s = pop_s;
      end
      leds_d = (state_d == ST_ON) ? (4'b0001 << colour_d) : 4'b0000;
      busy_d = (state_d != ST_IDLE);
   end

   // FIFO pointers, occupancy and sticky overflow
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (clear_s) begin
         wr_ptr_d   = {PW{1'b0}};
         rd_ptr_d   = {PW{1'b0}};
         count_d    = {CW{1'b0}};
         overflow_d = 1'b0;
      end else begin
         if (push_s && full_s) begin
            overflow_d = 1'b1;
         end else begin
            overflow_d = overflow_q;
         end
         if (do_push_s) begin
            mem_d[wr_ptr_q] = bus.dataIn[1:0];
            wr_ptr_d        = ptr_next(wr_ptr_q);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         timer_q    <= 32'd0;
         colour_q   <= 2'b00;
         wr_ptr_q   <= {PW{1'b0}};
         rd_ptr_q   <= {PW{1'b0}};
         count_q    <= {CW{1'b0}};
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         leds_q     <= 4'b0000;
         busy_q     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 2'b00;
         end
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         colour_q   <= colour_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         done_q     <= done_d;
         overflow_q <= overflow_d;
         leds_q     <= leds_d;
         busy_q     <= busy_d;
         mem_q      <= mem_d;
      end
   end

   assign busy       = busy_q;
   assign red_led    = leds_q[0];
   assign blue_led   = leds_q[1];
   assign green_led  = leds_q[2];
   assign yellow_led = leds_q[3];
endmodule
